// File: rtl/tpu_conv_sched.sv
// Sequences a 5x5 valid convolution of one stored feature map through the
// combinational 25-tap conv unit, gathering one window per output position.
module tpu_conv_sched #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int IMG_AW = 10,
  parameter int OUT_AW = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [IMG_AW-1:0] o_img_addr,
  input  logic [7:0]        i_img_data,
  output logic [4:0]        o_ker_addr,
  input  logic [7:0]        i_ker_data,
  output logic [199:0]      o_win_vec,
  output logic [199:0]      o_ker_vec,
  input  logic [7:0]        i_conv_data,
  input  logic              i_conv_ovf,
  output logic              o_out_we,
  output logic [OUT_AW-1:0] o_out_addr,
  output logic [7:0]        o_out_data,
  output logic              o_ovf_sticky
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0]     LAST_COL = CW'(IMG_W - 5);
  localparam logic [RW-1:0]     LAST_ROW = RW'(IMG_H - 5);
  localparam logic [IMG_AW-1:0] ROW_STEP = IMG_AW'(IMG_W - 4);
  localparam logic [4:0]        LAST_CNT = 5'd25;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_K, S_FETCH, S_WRITE, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [4:0]          r_cnt;
  logic [2:0]          r_tapC;
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic [IMG_AW-1:0]   r_base;
  logic [IMG_AW-1:0]   r_imgAddr;
  logic [4:0]          r_kerAddr;
  logic [199:0]        r_winVec;
  logic [199:0]        r_kerVec;
  logic [OUT_AW-1:0]   r_outAddr;
  logic                r_ovf;
  logic                w_phaseEnd;
  logic                w_lastPos;
  logic [IMG_AW-1:0]   w_nextBase;

  assign w_phaseEnd = (r_cnt == LAST_CNT);
  assign w_lastPos  = (r_row == LAST_ROW) && (r_col == LAST_COL);
  // Window origin of the next raster position; wrapping a row skips the 4 right-edge pixels.
  assign w_nextBase = (r_col == LAST_COL) ? r_base + IMG_AW'(5) : r_base + IMG_AW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_LOAD_K;
      S_LOAD_K: if (w_phaseEnd) w_next = S_FETCH;
      S_FETCH:  if (w_phaseEnd) w_next = S_WRITE;
      S_WRITE:  w_next = w_lastPos ? S_DONE : S_FETCH;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy   = 1'b0;
    o_done   = 1'b0;
    o_out_we = 1'b0;
    case (r_state)
      S_LOAD_K, S_FETCH: o_busy = 1'b1;
      S_WRITE: begin
        o_busy   = 1'b1;
        o_out_we = 1'b1;
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  // RAM data arrives one cycle after its address, so byte k-1 is captured on phase cycle k.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_tapC    <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_base    <= '0;
      r_imgAddr <= '0;
      r_kerAddr <= '0;
      r_winVec  <= '0;
      r_kerVec  <= '0;
      r_outAddr <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cnt     <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_base    <= '0;
            r_outAddr <= '0;
            r_ovf     <= 1'b0;
            r_kerAddr <= '0;
          end
        end
        S_LOAD_K: begin
          for (int b = 0; b < 25; b++) begin
            if (r_cnt == 5'(b + 1)) r_kerVec[8*b +: 8] <= i_ker_data;
          end
          if (r_cnt < 5'd24) r_kerAddr <= r_cnt + 5'd1;
          if (w_phaseEnd) begin
            r_cnt     <= '0;
            r_imgAddr <= r_base;
            r_tapC    <= '0;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_FETCH: begin
          for (int b = 0; b < 25; b++) begin
            if (r_cnt == 5'(b + 1)) r_winVec[8*b +: 8] <= i_img_data;
          end
          if (r_cnt < 5'd24) begin
            if (r_tapC == 3'd4) begin
              r_imgAddr <= r_imgAddr + ROW_STEP;
              r_tapC    <= '0;
            end else begin
              r_imgAddr <= r_imgAddr + IMG_AW'(1);
              r_tapC    <= r_tapC + 3'd1;
            end
          end
          if (w_phaseEnd) r_cnt <= '0;
          else            r_cnt <= r_cnt + 5'd1;
        end
        S_WRITE: begin
          if (i_conv_ovf) r_ovf <= 1'b1;
          if (!w_lastPos) begin
            r_outAddr <= r_outAddr + OUT_AW'(1);
            r_base    <= w_nextBase;
            r_imgAddr <= w_nextBase;
            r_tapC    <= '0;
            if (r_col == LAST_COL) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_img_addr   = r_imgAddr;
  assign o_ker_addr   = r_kerAddr;
  assign o_win_vec    = r_winVec;
  assign o_ker_vec    = r_kerVec;
  assign o_out_addr   = r_outAddr;
  assign o_out_data   = i_conv_data;
  assign o_ovf_sticky = r_ovf;

endmodule

// File: tb/tb_tpu_conv_sched.sv
// Self-checking bench for tpu_conv_sched: RAM and conv-unit models, a write
// scoreboard, a window vector table and cycle-exact timing/reset sequences.
module tb_tpu_conv_sched;

  localparam int IMG_W      = 28;
  localparam int IMG_H      = 28;
  localparam int IMG_AW     = 10;
  localparam int OUT_AW     = 10;
  localparam int OUT_W      = IMG_W - 4;
  localparam int N_OUT      = OUT_W * (IMG_H - 4);
  localparam int RUN_CYCLES = 26 + N_OUT * 27;

  typedef struct {
    logic [OUT_AW-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  typedef struct {
    int         wIdx;
    int         tap;
    logic [7:0] expByte;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [IMG_AW-1:0] imgAddr;
  logic [7:0]        imgData;
  logic [4:0]        kerAddr;
  logic [7:0]        kerData;
  logic [199:0]      winVec;
  logic [199:0]      kerVec;
  logic [7:0]        convData;
  logic              convOvf;
  logic              outWe;
  logic [OUT_AW-1:0] outAddr;
  logic [7:0]        outData;
  logic              ovf;
  logic              ovfEnable;

  int           passCnt;
  int           totalCnt;
  int           cyc;
  int           tStart;
  int           writeCount;
  int           busyCycles;
  int           doneCount;
  int           doneCycle;
  int           firstWriteCycle;
  bit           checkOvfNext;
  wr_t          sbQ[$];
  vec_t         vecs[8];
  logic [199:0] winSnap[N_OUT];
  logic [199:0] kerFirst;
  logic [199:0] kerLast;

  tpu_conv_sched #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .IMG_AW(IMG_AW), .OUT_AW(OUT_AW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_busy(busy), .o_done(done),
    .o_img_addr(imgAddr), .i_img_data(imgData),
    .o_ker_addr(kerAddr), .i_ker_data(kerData),
    .o_win_vec(winVec), .o_ker_vec(kerVec),
    .i_conv_data(convData), .i_conv_ovf(convOvf),
    .o_out_we(outWe), .o_out_addr(outAddr), .o_out_data(outData),
    .o_ovf_sticky(ovf)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    imgData <= imgAddr[7:0];
    kerData <= 8'h80 + {3'b000, kerAddr};
  end

  assign convData = winVec[7:0] ^ kerVec[7:0];
  assign convOvf  = ovfEnable && outWe && (outAddr == OUT_AW'(100));

  task automatic checkOutput(input string name, input logic [199:0] act, input logic [199:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic failNow(input string name);
    totalCnt++;
    $display("[TB] FAIL %s", name);
  endtask

  // Advance one cycle and sample just after the edge; all output monitoring lives here.
  task automatic stepCycle();
    wr_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busyCycles++;
    if (done) begin
      doneCount++;
      doneCycle = cyc;
      checkOutput("busy_at_done", busy, 0);
    end
    if (checkOvfNext) begin
      checkOutput("ovf_after_w100", ovf, 1);
      checkOvfNext = 1'b0;
    end
    if (outWe) begin
      if (sbQ.size() == 0) begin
        failNow("unexpected_write");
      end else begin
        e = sbQ.pop_front();
        checkOutput("wr_addr", outAddr, e.addr);
        checkOutput("wr_data", outData, e.data);
      end
      if (writeCount == 0) begin
        firstWriteCycle = cyc;
        kerFirst = kerVec;
      end
      if (writeCount == N_OUT - 1) kerLast = kerVec;
      if (writeCount < N_OUT) winSnap[writeCount] = winVec;
      if (ovfEnable && outAddr == OUT_AW'(100)) begin
        checkOutput("ovf_before_w100", ovf, 0);
        checkOvfNext = 1'b1;
      end
      writeCount++;
    end
  endtask

  // Load the scoreboard with every expected write, then pulse start for one cycle.
  task automatic applyStimulus();
    wr_t e;
    int  pix;
    sbQ.delete();
    for (int n = 0; n < N_OUT; n++) begin
      pix    = (n / OUT_W) * IMG_W + (n % OUT_W);
      e.addr = OUT_AW'(n);
      e.data = 8'(pix) ^ 8'h80;
      sbQ.push_back(e);
    end
    writeCount      = 0;
    busyCycles      = 0;
    doneCount       = 0;
    doneCycle       = -1;
    firstWriteCycle = -1;
    tStart          = cyc;
    start           = 1'b1;
    stepCycle();
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("ovf_cleared_on_start", ovf, 0);
  endtask

  task automatic waitDone(input int midStart);
    while (doneCount == 0 && (cyc - tStart) < RUN_CYCLES + 50) begin
      start = (midStart > 0 && cyc == tStart + midStart);
      stepCycle();
    end
    start = 1'b0;
    if (doneCount == 0) failNow("done_timeout");
    checkOutput("done_cycle", doneCycle, tStart + RUN_CYCLES + 1);
    checkOutput("busy_cycles", busyCycles, RUN_CYCLES);
    checkOutput("write_count", writeCount, N_OUT);
    checkOutput("sb_empty", sbQ.size(), 0);
    stepCycle();
    checkOutput("done_one_cycle", done, 0);
    checkOutput("done_count", doneCount, 1);
  endtask

  initial begin
    passCnt      = 0;
    totalCnt     = 0;
    cyc          = 0;
    writeCount   = 0;
    busyCycles   = 0;
    doneCount    = 0;
    checkOvfNext = 1'b0;
    ovfEnable    = 1'b0;
    rst          = 1'b1;
    start        = 1'b0;

    vecs[0] = '{0,   0,  8'd0};
    vecs[1] = '{0,   12, 8'd58};
    vecs[2] = '{0,   24, 8'd116};
    vecs[3] = '{26,  0,  8'd30};
    vecs[4] = '{26,  24, 8'd146};
    vecs[5] = '{300, 7,  8'h7A};
    vecs[6] = '{575, 0,  8'h9B};
    vecs[7] = '{575, 24, 8'h0F};

    repeat (2) stepCycle();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_out_we", outWe, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_img_addr", imgAddr, 0);
    checkOutput("rst_ker_addr", kerAddr, 0);
    checkOutput("rst_out_addr", outAddr, 0);
    checkOutput("rst_win_vec", winVec, 0);
    checkOutput("rst_ker_vec", kerVec, 0);
    rst = 1'b0;
    stepCycle();

    $display("[TB] run 1: full run, overflow on write 100, stray start mid-run");
    ovfEnable = 1'b1;
    applyStimulus();
    waitDone(3000);
    checkOutput("first_write_cycle", firstWriteCycle, tStart + 53);
    checkOutput("ovf_after_done", ovf, 1);
    ovfEnable = 1'b0;

    for (int t = 0; t < 25; t++) begin
      checkOutput("win_first", winSnap[0][8*t +: 8], 8'((t / 5) * IMG_W + (t % 5)));
      checkOutput("ker_first", kerFirst[8*t +: 8], 8'h80 + 8'(t));
      checkOutput("ker_last", kerLast[8*t +: 8], 8'h80 + 8'(t));
    end
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("win_w%0d_t%0d", vecs[i].wIdx, vecs[i].tap),
                  winSnap[vecs[i].wIdx][8*vecs[i].tap +: 8], vecs[i].expByte);
    end

    $display("[TB] run 2: reset during FETCH of write 10");
    repeat (3) stepCycle();
    checkOutput("ovf_held_idle", ovf, 1);
    applyStimulus();
    while (writeCount < 10 && (cyc - tStart) < 2000) stepCycle();
    if (writeCount < 10) failNow("run2_write_timeout");
    repeat (5) stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_out_we", outWe, 0);
    checkOutput("abort_win_vec", winVec, 0);
    sbQ.delete();
    repeat (200) stepCycle();
    checkOutput("abort_no_writes", writeCount, 10);
    checkOutput("abort_idle", busy, 0);

    $display("[TB] run 3: fresh run after abort");
    applyStimulus();
    waitDone(0);
    checkOutput("run3_first_write_cycle", firstWriteCycle, tStart + 53);
    checkOutput("run3_ovf", ovf, 0);
    checkOutput("run3_win_last", winSnap[N_OUT-1][8*24 +: 8], 8'h0F);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/tpu_conv_sched.md
Name: tpu_conv_sched

Overview:
Sequencer that runs a 5x5 valid convolution of one stored feature map through the combinational 25-tap Float8 dot-product unit (TPU conv unit).
- Loads the 25 kernel bytes once per run.
- For each output position in raster order, gathers the 5x5 window from image RAM, presents window and kernel to the conv unit, and writes the result to output RAM.
- Sits between the layer-control FSM (start/done) and the image, kernel and output RAMs.

Parameters:
IMG_W, 28, image width in pixels
IMG_H, 28, image height in pixels
IMG_AW, 10, image RAM address width (must hold IMG_W*IMG_H-1)
OUT_AW, 10, output RAM address width (must hold (IMG_W-4)*(IMG_H-4)-1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  run request, sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse, run complete
img_addr  out  IMG_AW  image RAM read address
img_data  in  8  image RAM data, valid 1 cycle after img_addr
ker_addr  out  5  kernel RAM read address, 0..24
ker_data  in  8  kernel RAM data, valid 1 cycle after ker_addr
win_vec  out  200  window to conv unit data_in1; byte i = bits 8i+7:8i
ker_vec  out  200  kernel to conv unit data_in2, same packing
conv_data  in  8  conv unit data_out (combinational from win_vec/ker_vec)
conv_ovf  in  1  conv unit overflow
out_we  out  1  output RAM write strobe
out_addr  out  OUT_AW  output write address
out_data  out  8  output write data
ovf_sticky  out  1  set if any written result had conv_ovf=1

Behaviour:
- Reset: state IDLE; busy, done, out_we, ovf_sticky = 0; all addresses = 0; win_vec, ker_vec = 0; row/col counters = 0. Reset mid-run aborts immediately and issues no further writes.
- Tap index i = r*5 + c, with r, c in 0..4. Pixel address = (row+r)*IMG_W + (col+c). Output address = row*(IMG_W-4) + col.
- States and transitions:
  - IDLE: start=1 -> LOAD_K. On the same edge ovf_sticky, row and col clear. start is ignored in every other state.
  - LOAD_K, 26 cycles: cycles 0..24 drive ker_addr = k. On cycles 1..25 ker_data is written into ker_vec byte k-1. Then FETCH.
  - FETCH, 26 cycles: cycles 0..24 drive img_addr for tap i. On cycles 1..25 img_data is written into win_vec byte i-1. Then WRITE.
  - WRITE, 1 cycle:
    - out_we = 1, out_data = conv_data, out_addr = current position.
    - If conv_ovf = 1, ovf_sticky sets.
    - Position advance: col+1. At col = IMG_W-5, col wraps to 0 and row+1.
    - If the written position was the last one (row = IMG_H-5, col = IMG_W-5) -> DONE; otherwise -> FETCH.
  - DONE, 1 cycle: done = 1, busy = 0 -> IDLE.
- Outputs outside their phase:
  - out_we is high only in WRITE.
  - img_addr and ker_addr hold their last value outside their phases.
  - win_vec and ker_vec are registered and hold between updates. ker_vec is stable through the whole run.
- Latency with defaults: 26 + 576*27 = 15578 busy cycles, then 1 done cycle.
- ovf_sticky holds after done until the next accepted start or rst.
- start held high through done starts a new run on the IDLE cycle after DONE.

Test Plan:
- Bench conv model: conv_data = win_vec[7:0] ^ ker_vec[7:0], conv_ovf driven by bench.
- Image RAM models img_data = addr[7:0]; kernel models ker_data = 8'h80+addr; start pulse.
  - At first WRITE, win_vec bytes 0..24 = {0..4, 28..32, 56..60, 84..88, 112..116} and ker_vec byte 24 = 8'h98.
  - out_addr = 0, out_data = 8'h00^8'h80 = 8'h80.
- Same run, count out_we pulses: exactly 576, with out_addr sequence 0..575 and no gaps or repeats.
  - Output (row 1, col 2): out_addr = 26, win_vec byte 0 = 30.
  - Output (row 23, col 23): out_addr = 575, win_vec byte 24 = 8'h0F (783[7:0]).
- Cycle count: start at cycle T -> busy high T+1..T+15578, done = 1 only at cycle T+15579, busy = 0 at that cycle.
  - A start pulse issued mid-run produces no effect.
- Overflow: conv_ovf = 1 only during write #100 -> ovf_sticky = 1 from the next cycle, still 1 after done, cleared on the next accepted start.
- rst asserted during FETCH of write #10:
  - Next cycle: busy = 0, out_we = 0, win_vec = 0, and no further writes occur.
  - A fresh start restarts at out_addr = 0 with a full LOAD_K.
